// File: rtl/ldst_mem_bridge_if.sv
// rtl/ldst_mem_bridge_if.sv - CPU load/store, RAM and MMIO signal bundle for ldst_mem_bridge
interface ldst_mem_bridge_if #(
    parameter int RAM_ADDR_W = 11
);
    logic [15:0]           i_ldst_addr;
    logic                  i_ldst_rd;
    logic                  i_ldst_wr;
    logic [15:0]           i_ldst_wrdata;
    logic [15:0]           o_ldst_rddata;
    logic                  o_ldst_stall;
    logic [RAM_ADDR_W-1:0] o_ram_addr;
    logic                  o_ram_wr;
    logic [15:0]           o_ram_wrdata;
    logic [15:0]           i_ram_rddata;
    logic [15:0]           o_mmio_address;
    logic                  o_mmio_read;
    logic                  o_mmio_write;
    logic [15:0]           o_mmio_writedata;
    logic [15:0]           i_mmio_readdata;
    logic                  i_mmio_waitrequest;
    logic                  o_bus_err;

    // Environment side: CPU, RAM macro and peripheral bus
    modport master (
        output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
        input  o_ldst_rddata, o_ldst_stall,
        input  o_ram_addr, o_ram_wr, o_ram_wrdata,
        output i_ram_rddata,
        input  o_mmio_address, o_mmio_read, o_mmio_write, o_mmio_writedata,
        output i_mmio_readdata, i_mmio_waitrequest,
        input  o_bus_err
    );

    // Bridge side
    modport slave (
        input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
        output o_ldst_rddata, o_ldst_stall,
        output o_ram_addr, o_ram_wr, o_ram_wrdata,
        input  i_ram_rddata,
        output o_mmio_address, o_mmio_read, o_mmio_write, o_mmio_writedata,
        input  i_mmio_readdata, i_mmio_waitrequest,
        output o_bus_err
    );
endinterface

// File: rtl/ldst_mem_bridge.sv
// rtl/ldst_mem_bridge.sv - routes CPU loads/stores to data RAM or the MMIO bus with timeout
module ldst_mem_bridge #(
    parameter int          RAM_ADDR_W     = 11,
    parameter logic [3:0]  MMIO_PAGE      = 4'hF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    ldst_mem_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      next_state;

    logic        req;
    logic        is_mmio;
    logic        wait_hi;
    logic        timeout;
    logic        start;

    logic        kind_wr_q;
    logic [7:0]  tcnt;
    logic [15:0] rdata_q;
    logic        rsel_q;        // 1: load data comes from rdata_q (MMIO), 0: from RAM
    logic [15:0] addr_q;
    logic [15:0] wrdata_q;
    logic        bus_err_q;

    logic        stall;
    logic        mmio_read;
    logic        mmio_write;
    logic        ram_wr;

    // Address bits outside the RAM window and the byte-select bit are not needed here
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_ldst_addr[0], bus.i_ldst_addr[15:RAM_ADDR_W+1]};

    assign req     = bus.i_ldst_rd | bus.i_ldst_wr;
    assign is_mmio = (bus.i_ldst_addr[15:12] == MMIO_PAGE);
    assign wait_hi = bus.i_mmio_waitrequest;
    assign timeout = wait_hi && (tcnt == 8'(TIMEOUT_CYCLES - 1));
    assign start   = (state == IDLE) && req && is_mmio;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req && is_mmio) next_state = BUSY;
            BUSY:    if (!wait_hi || timeout) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; everything forced quiet while reset is held
    always_comb begin
        stall      = 1'b0;
        mmio_read  = 1'b0;
        mmio_write = 1'b0;
        ram_wr     = 1'b0;
        case (state)
            IDLE: begin
                stall  = req && is_mmio;
                ram_wr = bus.i_ldst_wr && !is_mmio;
            end
            BUSY: begin
                stall      = 1'b1;
                mmio_read  = !kind_wr_q;
                mmio_write = kind_wr_q;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        if (!reset) begin
            stall      = 1'b0;
            mmio_read  = 1'b0;
            mmio_write = 1'b0;
            ram_wr     = 1'b0;
        end
    end

    // MMIO capture, wait/timeout counting, read-return capture and load-source select
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= 16'h0000;
            wrdata_q  <= 16'h0000;
            kind_wr_q <= 1'b0;
            tcnt      <= 8'h00;
            rdata_q   <= 16'h0000;
            rsel_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q    <= bus.i_ldst_addr;
                wrdata_q  <= bus.i_ldst_wrdata;
                kind_wr_q <= bus.i_ldst_wr;
                tcnt      <= 8'h00;
            end
            if (state == BUSY) begin
                if (!wait_hi) begin
                    if (!kind_wr_q) rdata_q <= bus.i_mmio_readdata;
                end else if (timeout) begin
                    rdata_q   <= 16'hDEAD;
                    bus_err_q <= 1'b1;
                end else if (tcnt != 8'hFF) begin
                    tcnt <= tcnt + 8'h01;
                end
            end
            // An accepted load (including the DONE re-presentation) picks the return path
            if (!stall && bus.i_ldst_rd && !bus.i_ldst_wr) begin
                rsel_q <= is_mmio;
            end
        end
    end

    assign bus.o_ram_addr       = bus.i_ldst_addr[RAM_ADDR_W:1];
    assign bus.o_ram_wrdata     = bus.i_ldst_wrdata;
    assign bus.o_ram_wr         = ram_wr;
    assign bus.o_ldst_stall     = stall;
    assign bus.o_ldst_rddata    = rsel_q ? rdata_q : bus.i_ram_rddata;
    assign bus.o_mmio_address   = addr_q;
    assign bus.o_mmio_writedata = wrdata_q;
    assign bus.o_mmio_read      = mmio_read;
    assign bus.o_mmio_write     = mmio_write;
    assign bus.o_bus_err        = bus_err_q;
endmodule

// File: tb/tb_ldst_mem_bridge.sv
// tb/tb_ldst_mem_bridge.sv - self-checking bench for ldst_mem_bridge
module tb_ldst_mem_bridge;
    localparam int AW      = 11;
    localparam int TIMEOUT = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldst_mem_bridge_if #(.RAM_ADDR_W(AW)) bus ();

    ldst_mem_bridge #(
        .RAM_ADDR_W(AW),
        .MMIO_PAGE(4'hF),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    // Synchronous RAM macro model
    logic [15:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.o_ram_wr) ram[bus.o_ram_addr] <= bus.o_ram_wrdata;
        bus.i_ram_rddata <= ram[bus.o_ram_addr];
    end

    int checks   = 0;
    int failures = 0;

    // Reference: word contents written so far and the expected sticky error
    logic [15:0] ref_mem [int];
    logic        bus_err_exp;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.i_ldst_rd     = 1'b0;
        bus.i_ldst_wr     = 1'b0;
    endtask

    task automatic ram_write(input logic [15:0] addr, input logic [15:0] data);
        next_cycle();
        bus.i_ldst_addr   = addr;
        bus.i_ldst_wrdata = data;
        bus.i_ldst_wr     = 1'b1;
        bus.i_ldst_rd     = 1'b0;
        #1;
        checks++;
        if (bus.o_ram_wr !== 1'b1 || bus.o_ram_addr !== addr[AW:1] || bus.o_ldst_stall !== 1'b0) begin
            failures++;
            $display("FAIL ram_write addr=%h: ram_wr=%b ram_addr=%h stall=%b, want 1/%h/0",
                     addr, bus.o_ram_wr, bus.o_ram_addr, bus.o_ldst_stall, addr[AW:1]);
        end
        ref_mem[int'(addr[AW:1])] = data;
    endtask

    task automatic ram_read_check(input logic [15:0] addr);
        logic [15:0] exp;
        exp = ref_mem[int'(addr[AW:1])];
        next_cycle();
        bus.i_ldst_addr = addr;
        bus.i_ldst_rd   = 1'b1;
        bus.i_ldst_wr   = 1'b0;
        #1;
        checks++;
        if (bus.o_ldst_stall !== 1'b0 || bus.o_ram_wr !== 1'b0) begin
            failures++;
            $display("FAIL ram_read_req addr=%h: stall=%b ram_wr=%b, want 0/0",
                     addr, bus.o_ldst_stall, bus.o_ram_wr);
        end
        next_cycle();
        set_idle();
        #1;
        checks++;
        if (bus.o_ldst_rddata !== exp || bus.o_bus_err !== bus_err_exp) begin
            failures++;
            $display("FAIL ram_read_data addr=%h: data=%h bus_err=%b, want %h/%b",
                     addr, bus.o_ldst_rddata, bus.o_bus_err, exp, bus_err_exp);
        end
    endtask

    // One complete MMIO access; waits >= TIMEOUT means the peripheral never answers
    task automatic mmio_access(input logic is_wr, input logic [15:0] addr, input logic [15:0] wd,
                               input int waits, input logic [15:0] rret,
                               input logic chk_prev, input logic [15:0] prev);
        int          exp_stall;
        int          exp_strobe;
        logic [15:0] exp_rd;
        int          stall_cnt;
        int          strobe_cnt;
        int          bad;
        int          ram_wr_seen;
        logic        done;
        if (waits >= TIMEOUT) begin
            exp_stall   = TIMEOUT + 1;
            exp_rd      = 16'hDEAD;
            bus_err_exp = 1'b1;
        end else begin
            exp_stall = waits + 2;
            exp_rd    = rret;
        end
        exp_strobe  = exp_stall - 1;
        stall_cnt   = 0;
        strobe_cnt  = 0;
        bad         = 0;
        ram_wr_seen = 0;
        done        = 1'b0;

        next_cycle();
        bus.i_ldst_addr        = addr;
        bus.i_ldst_wrdata      = wd;
        bus.i_ldst_wr          = is_wr;
        bus.i_ldst_rd          = !is_wr;
        bus.i_mmio_waitrequest = 1'b1;
        bus.i_mmio_readdata    = rret;
        #1;
        if (chk_prev) begin
            checks++;
            if (bus.o_ldst_rddata !== prev || bus.o_ldst_stall !== 1'b1) begin
                failures++;
                $display("FAIL b2b_overlap: data=%h stall=%b, want %h/1",
                         bus.o_ldst_rddata, bus.o_ldst_stall, prev);
            end
        end
        for (int c = 0; c < 400 && !done; c++) begin
            if (c > 0) begin
                next_cycle();
                bus.i_mmio_waitrequest = (c - 1 < waits);
                #1;
            end
            if (bus.o_ldst_stall === 1'b1) stall_cnt++;
            else done = 1'b1;
            if (bus.o_mmio_read === 1'b1 || bus.o_mmio_write === 1'b1) begin
                strobe_cnt++;
                if (bus.o_mmio_address !== addr || bus.o_mmio_read !== !is_wr ||
                    bus.o_mmio_write !== is_wr || (is_wr && bus.o_mmio_writedata !== wd))
                    bad++;
            end
            if (bus.o_ram_wr !== 1'b0) ram_wr_seen++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL mmio_no_completion addr=%h: stall still high after 400 cycles", addr);
        end
        checks++;
        if (stall_cnt != exp_stall || strobe_cnt != exp_strobe) begin
            failures++;
            $display("FAIL mmio_timing addr=%h waits=%0d: stall=%0d strobe=%0d, want %0d/%0d",
                     addr, waits, stall_cnt, strobe_cnt, exp_stall, exp_strobe);
        end
        checks++;
        if (bad != 0 || ram_wr_seen != 0) begin
            failures++;
            $display("FAIL mmio_bus_fields addr=%h: bad_cycles=%0d ram_wr_cycles=%0d, want 0/0",
                     addr, bad, ram_wr_seen);
        end
        next_cycle();
        set_idle();
        bus.i_mmio_waitrequest = 1'b0;
        #1;
        checks++;
        if ((!is_wr && bus.o_ldst_rddata !== exp_rd) || bus.o_bus_err !== bus_err_exp ||
            bus.o_ldst_stall !== 1'b0 || bus.o_mmio_read !== 1'b0 || bus.o_mmio_write !== 1'b0) begin
            failures++;
            $display("FAIL mmio_result addr=%h: data=%h bus_err=%b stall=%b rd=%b wr=%b, want %h/%b/0/0/0",
                     addr, bus.o_ldst_rddata, bus.o_bus_err, bus.o_ldst_stall,
                     bus.o_mmio_read, bus.o_mmio_write, exp_rd, bus_err_exp);
        end
    endtask

    task automatic test_reset();
        set_idle();
        bus.i_ldst_addr        = 16'h0000;
        bus.i_ldst_wrdata      = 16'h0000;
        bus.i_mmio_waitrequest = 1'b0;
        bus.i_mmio_readdata    = 16'h0000;
        bus_err_exp            = 1'b0;
        rst_n                  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (bus.o_ldst_stall !== 1'b0 || bus.o_mmio_read !== 1'b0 || bus.o_mmio_write !== 1'b0 ||
            bus.o_mmio_address !== 16'h0 || bus.o_mmio_writedata !== 16'h0 || bus.o_bus_err !== 1'b0 ||
            bus.o_ram_wr !== 1'b0 || bus.o_ldst_rddata !== bus.i_ram_rddata) begin
            failures++;
            $display("FAIL reset_state: stall=%b rd=%b wr=%b addr=%h wd=%h err=%b ram_wr=%b data=%h ram=%h",
                     bus.o_ldst_stall, bus.o_mmio_read, bus.o_mmio_write, bus.o_mmio_address,
                     bus.o_mmio_writedata, bus.o_bus_err, bus.o_ram_wr, bus.o_ldst_rddata, bus.i_ram_rddata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ram_rw();
        logic [15:0] addrs [8];
        ram_write(16'h0010, 16'h1234);
        ram_read_check(16'h0010);
        for (int k = 0; k < 8; k++) begin
            addrs[k] = {4'($urandom_range(0, 14)), 11'($urandom), 1'b0};
            ram_write(addrs[k], 16'($urandom));
        end
        for (int k = 7; k >= 0; k--) ram_read_check(addrs[k]);
    endtask

    task automatic test_mmio();
        mmio_access(1'b0, 16'hF004, 16'h0000, 3, 16'hBEEF, 1'b0, 16'h0);
        mmio_access(1'b1, 16'hF000, 16'h00A5, 0, 16'h0000, 1'b0, 16'h0);
        for (int k = 0; k < 6; k++) begin
            mmio_access(1'($urandom), {4'hF, 12'($urandom)}, 16'($urandom),
                        $urandom_range(0, 6), 16'($urandom), 1'b0, 16'h0);
        end
    endtask

    task automatic test_timeout();
        mmio_access(1'b0, 16'hF008, 16'h0000, 1000, 16'h1357, 1'b0, 16'h0);
        ram_write(16'h0042, 16'h6A6A);
        ram_read_check(16'h0042);
    endtask

    task automatic test_reset_mid();
        next_cycle();
        bus.i_ldst_addr        = 16'hF00C;
        bus.i_ldst_rd          = 1'b1;
        bus.i_ldst_wr          = 1'b0;
        bus.i_mmio_waitrequest = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (bus.o_mmio_read !== 1'b1 || bus.o_ldst_stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_busy: read=%b stall=%b, want 1/1", bus.o_mmio_read, bus.o_ldst_stall);
        end
        rst_n = 1'b0;
        bus_err_exp = 1'b0;
        #1;
        checks++;
        if (bus.o_mmio_read !== 1'b0 || bus.o_ldst_stall !== 1'b0 || bus.o_bus_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: read=%b stall=%b bus_err=%b, want 0/0/0",
                     bus.o_mmio_read, bus.o_ldst_stall, bus.o_bus_err);
        end
        set_idle();
        bus.i_mmio_waitrequest = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        mmio_access(1'b0, 16'hF00E, 16'h0000, $urandom_range(0, 4), 16'h4C4C, 1'b0, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1;
        logic [15:0] d3;
        d1 = 16'($urandom);
        d3 = 16'($urandom);
        ram_write(16'h0020, d1);
        next_cycle();
        bus.i_ldst_addr = 16'h0020;
        bus.i_ldst_rd   = 1'b1;
        bus.i_ldst_wr   = 1'b0;
        #1;
        checks++;
        if (bus.o_ldst_stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ram_req: stall=%b, want 0", bus.o_ldst_stall);
        end
        mmio_access(1'b0, 16'hF002, 16'h0000, 1, ~d1, 1'b1, d1);
        next_cycle();
        bus.i_ldst_addr   = 16'h0030;
        bus.i_ldst_wrdata = d3;
        bus.i_ldst_rd     = 1'b1;
        bus.i_ldst_wr     = 1'b1;
        #1;
        checks++;
        if (bus.o_ram_wr !== 1'b1 || bus.o_ldst_stall !== 1'b0 || bus.o_ram_addr !== 11'h018) begin
            failures++;
            $display("FAIL conflict_write: ram_wr=%b stall=%b ram_addr=%h, want 1/0/018",
                     bus.o_ram_wr, bus.o_ldst_stall, bus.o_ram_addr);
        end
        ref_mem[int'(11'h018)] = d3;
        next_cycle();
        set_idle();
        #1;
        checks++;
        if (bus.o_ldst_rddata !== ~d1) begin
            failures++;
            $display("FAIL conflict_rsel: data=%h, want %h (previous MMIO result)", bus.o_ldst_rddata, ~d1);
        end
        ram_read_check(16'h0030);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'h0000;
        test_reset();
        test_ram_rw();
        test_mmio();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ldst_mem_bridge.md
Name: ldst_mem_bridge

Overview:
Sits directly downstream of the CPU load/store port and routes each access either to the on-chip data RAM or to the MMIO peripheral bus. RAM accesses complete with zero stall and one-cycle read latency. MMIO accesses use a waitrequest handshake, stall the CPU until they complete, and include a timeout so a hung peripheral cannot hang the core.

Parameters:
RAM_ADDR_W, 11, RAM word-address width (RAM is 2^RAM_ADDR_W x 16 bits)
MMIO_PAGE, 4'hF, value of addr[15:12] that selects the MMIO bus
TIMEOUT_CYCLES, 255, maximum BUSY cycles with waitrequest high before the access is aborted

Ports:
clk  in  1  clock; all logic is clocked on the rising edge
reset  in  1  asynchronous, active-low reset
i_ldst_addr  in  16  CPU byte address
i_ldst_rd  in  1  CPU load request
i_ldst_wr  in  1  CPU store request
i_ldst_wrdata  in  16  CPU store data
o_ldst_rddata  out  16  load data to the CPU
o_ldst_stall  out  1  CPU must hold its request and freeze while this is high
o_ram_addr  out  RAM_ADDR_W  RAM word address, equal to i_ldst_addr[RAM_ADDR_W:1]
o_ram_wr  out  1  RAM write enable
o_ram_wrdata  out  16  RAM write data
i_ram_rddata  in  16  RAM synchronous read data, valid one cycle after the address is presented
o_mmio_address  out  16  MMIO byte address (registered)
o_mmio_read  out  1  MMIO read strobe
o_mmio_write  out  1  MMIO write strobe
o_mmio_writedata  out  16  MMIO write data (registered)
i_mmio_readdata  in  16  valid in any cycle where read is high and waitrequest is low
i_mmio_waitrequest  in  1  peripheral not ready; strobes and address must be held
o_bus_err  out  1  sticky flag: an MMIO timeout has occurred

Behaviour:
- Request decode: req = i_ldst_rd | i_ldst_wr.
  - If both rd and wr are asserted, the access is a write and rd is ignored.
  - is_mmio = (i_ldst_addr[15:12] == MMIO_PAGE); otherwise the access goes to RAM.
- RAM path: combinational passthrough of address and data.
  - o_ram_wr = i_ldst_wr & ~is_mmio & (state==IDLE).
  - Never stalls.
- Read-return mux select: rsel_q is a register loaded in any cycle with stall low, rd high and wr low.
  - rsel_q = RAM when the address decodes to RAM, MMIO otherwise.
  - o_ldst_rddata = i_ram_rddata when rsel_q==RAM, rdata_q when rsel_q==MMIO.
  - Load data is therefore valid exactly one cycle after the accepting cycle, for both targets.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - req & is_mmio: stall=1 (combinational); capture addr, wrdata and read/write kind; clear tcnt; go to BUSY.
    - Otherwise stall=0.
  - BUSY:
    - stall=1. o_mmio_read or o_mmio_write is driven high from the captured kind.
    - waitrequest low: for a read, rdata_q <= i_mmio_readdata; go to DONE.
    - waitrequest high and tcnt==TIMEOUT_CYCLES-1: drop strobes next cycle; rdata_q <= 16'hDEAD; o_bus_err <= 1; go to DONE.
    - Otherwise tcnt++ (8-bit counter, saturating, sized to cover TIMEOUT_CYCLES).
  - DONE:
    - stall=0. The CPU request still present is the same access and is treated as accepted: rsel_q is loaded, no new MMIO access starts, and o_ram_wr stays 0.
    - Always go to IDLE.
- MMIO timing: a zero-wait MMIO access stalls for 2 cycles (IDLE, BUSY). Each waitrequest cycle adds 1.
- Strobes are asserted only in BUSY. o_mmio_address and o_mmio_writedata are stable for the whole of BUSY.
- o_bus_err is cleared only by reset.
- Reset values (asynchronous, take effect immediately, including mid-BUSY):
  - state=IDLE; o_ldst_stall=0; o_mmio_read=0; o_mmio_write=0.
  - o_mmio_address=0; o_mmio_writedata=0; rdata_q=0; rsel_q=RAM; tcnt=0; o_bus_err=0.
  - o_ldst_rddata therefore equals i_ram_rddata after reset.
- No request: no strobes, stall=0, o_ram_wr=0.

Test Plan:
1. RAM store then load:
   - wr 0x1234 to addr 0x0010; next cycle rd 0x0010.
   - Expect o_ram_wr for one cycle with o_ram_addr=8, stall never high.
   - o_ldst_rddata=0x1234 in the cycle after the rd cycle.
2. MMIO read with waits:
   - rd at 0xF004; peripheral holds waitrequest high for 3 BUSY cycles, then returns 0xBEEF.
   - Expect stall high for 5 cycles, o_mmio_read high for 4 cycles, address 0xF004 throughout.
   - o_ldst_rddata=0xBEEF in the cycle after DONE.
3. MMIO zero-wait write:
   - wr 0x00A5 to 0xF000.
   - Expect stall high for exactly 2 cycles, o_mmio_write high for 1 cycle with writedata 0x00A5.
   - o_ram_wr stays 0 throughout.
4. Timeout:
   - rd at 0xF008 with waitrequest held high permanently.
   - Expect strobe low after 255 BUSY cycles, o_bus_err=1 and staying 1, o_ldst_rddata=0xDEAD.
   - A following RAM read completes normally.
5. Reset mid-operation:
   - Assert reset (low) during the 2nd BUSY cycle of an MMIO read.
   - Expect o_mmio_read=0 and stall=0 immediately, without waiting for a clock edge.
   - After release, a new MMIO read completes normally.
6. Back-to-back and conflict:
   - RAM rd 0x0020 immediately followed by MMIO rd 0xF002.
   - Expect the RAM data to arrive and MMIO stall to begin in the same cycle, with no interference between them.
   - rd+wr together at 0x0030: expect a RAM write occurs and rsel_q is not loaded.
